dual_input_debouncer: RTL and testbench

- Upstream conditioning stage for the two-input logic gate block.
- Takes two raw, asynchronous switch/button levels.
- Synchronises each level into the clock domain, debounces it, and drives clean single-bit levels a and b directly into the gate's a and b inputs.
- Both channels are identical and fully independent.

---
 rtl/dual_input_debouncer.sv | 201 ++++++++++++++++++++
 tb/tb_dual_input_debouncer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dual_input_debouncer.sv
// Two-channel synchronise-and-debounce front end driving the gate's a/b inputs.
// Define DEBOUNCE_HOLD_EN to add a post-change HOLD lockout to each channel.

module dual_input_debouncer_chan #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

`ifdef DEBOUNCE_HOLD_EN
    typedef enum logic [2:0] {
        STABLE_LOW  = 3'd0,
        WAIT_HIGH   = 3'd1,
        STABLE_HIGH = 3'd2,
        WAIT_LOW    = 3'd3,
        HOLD_HIGH   = 3'd4,
        HOLD_LOW    = 3'd5
    } state_e;
    localparam state_e ENTER_HIGH = HOLD_HIGH;
    localparam state_e ENTER_LOW  = HOLD_LOW;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(DEBOUNCE_CYCLES);
`else
    typedef enum logic [2:0] {
        STABLE_LOW  = 3'd0,
        WAIT_HIGH   = 3'd1,
        STABLE_HIGH = 3'd2,
        WAIT_LOW    = 3'd3
    } state_e;
    localparam state_e ENTER_HIGH = STABLE_HIGH;
    localparam state_e ENTER_LOW  = STABLE_LOW;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit               SKIP_WAIT = (DEBOUNCE_CYCLES == 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             out_q, out_d;
    logic             rise_q, rise_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
        end
    end

    always_comb begin
        s1_d    = raw;
        s2_d    = s1_q;
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            STABLE_LOW: begin
                out_d = 1'b0;
                cnt_d = '0;
                if (s2_q) begin
                    if (SKIP_WAIT) begin
                        state_d = ENTER_HIGH;
                        out_d   = 1'b1;
                    end else begin
                        state_d = WAIT_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            WAIT_HIGH: begin
                out_d = 1'b0;
                if (!s2_q) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ENTER_HIGH;
                    out_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            STABLE_HIGH: begin
                out_d = 1'b1;
                cnt_d = '0;
                if (!s2_q) begin
                    if (SKIP_WAIT) begin
                        state_d = ENTER_LOW;
                        out_d   = 1'b0;
                    end else begin
                        state_d = WAIT_LOW;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            WAIT_LOW: begin
                out_d = 1'b1;
                if (s2_q) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ENTER_LOW;
                    out_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
`ifdef DEBOUNCE_HOLD_EN
            // Exit from HOLD enters WAIT with zero progress so a reversal needs a full fresh window.
            HOLD_HIGH: begin
                out_d = 1'b1;
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = s2_q ? STABLE_HIGH : WAIT_LOW;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HOLD_LOW: begin
                out_d = 1'b0;
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = s2_q ? WAIT_HIGH : STABLE_LOW;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
`endif
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
                out_d   = 1'b0;
            end
        endcase
        rise_d = out_d & ~out_q;
    end

    assign level = out_q;
    assign rise  = rise_q;

endmodule

module dual_input_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_a,
    input  logic raw_b,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic b_rise
);

    dual_input_debouncer_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_chan_a (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (raw_a),
        .level(a),
        .rise (a_rise)
    );

    dual_input_debouncer_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_chan_b (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (raw_b),
        .level(b),
        .rise (b_rise)
    );

endmodule

// File: tb/tb_dual_input_debouncer.sv
// Scoreboard bench for dual_input_debouncer: DEBOUNCE_CYCLES=4 and =1 instances share stimulus.

module tb_dual_input_debouncer;

    localparam int NCH = 4;
    localparam int DEB [NCH] = '{4, 4, 1, 1};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic raw_a = 1'b1;
    logic raw_b = 1'b1;
    logic a4, b4, ar4, br4;
    logic a1, b1, ar1, br1;

    dual_input_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .raw_a(raw_a), .raw_b(raw_b),
        .a(a4), .b(b4), .a_rise(ar4), .b_rise(br4)
    );

    dual_input_debouncer #(.DEBOUNCE_CYCLES(1), .CNT_W(16)) dut_d1 (
        .clk(clk), .rst_n(rst_n), .raw_a(raw_a), .raw_b(raw_b),
        .a(a1), .b(b1), .a_rise(ar1), .b_rise(br1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] lvl;
        logic [3:0] rise;
        logic       mid;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   stim_done = 1'b0;

    // Reference model: s2 history per channel; output flips once the last DEB samples all disagree with it.
    bit       m_s1   [NCH];
    bit       m_s2   [NCH];
    bit       m_out  [NCH];
    bit [7:0] m_hist [NCH];

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_s1[i]   = 1'b0;
            m_s2[i]   = 1'b0;
            m_out[i]  = 1'b0;
            m_hist[i] = '0;
        end
    endtask

    task automatic model_edge(input bit ra, input bit rb,
                              output logic [3:0] lvl, output logic [3:0] rise);
        bit raw_v [NCH];
        bit seen;
        bit all_diff;
        raw_v = '{ra, rb, ra, rb};
        for (int i = 0; i < NCH; i++) begin
            seen      = m_s2[i];
            m_s2[i]   = m_s1[i];
            m_s1[i]   = raw_v[i];
            m_hist[i] = {m_hist[i][6:0], seen};
            all_diff  = 1'b1;
            for (int k = 0; k < DEB[i]; k++)
                if (m_hist[i][k] == m_out[i]) all_diff = 1'b0;
            rise[i] = 1'b0;
            if (all_diff) begin
                m_out[i] = ~m_out[i];
                rise[i]  = m_out[i];
            end
            lvl[i] = m_out[i];
        end
    endtask

    task automatic step(input bit ra, input bit rb, input bit rn, input bit drop);
        exp_t       e;
        logic [3:0] l, r;
        @(negedge clk);
        raw_a = ra;
        raw_b = rb;
        rst_n = rn;
        if (!rn) begin
            model_reset();
            l = '0;
            r = '0;
        end else begin
            model_edge(ra, rb, l, r);
        end
        e.lvl  = l;
        e.rise = r;
        e.mid  = drop;
        sb_q.push_back(e);
        if (drop) begin
            @(posedge clk);
            #3;
            rst_n = 1'b0;
            model_reset();
        end
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b expected %b (bits b1 a1 b4 a4)", name, $time, act, exp_v);
        end
    endtask

    initial begin : stim
        int unsigned rem_a, rem_b;
        bit          ra, rb, drop, in_rst;
        rem_a  = 0;
        rem_b  = 0;
        ra     = 1'b0;
        rb     = 1'b0;
        in_rst = 1'b0;
        model_reset();

        repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (8)  step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (10) step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3)  step(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (8)  step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (10) step(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (10) step(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3)  step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (12) step(1'b1, 1'b1, 1'b1, 1'b0);

        for (int c = 0; c < 2000; c++) begin
            if (rem_a == 0) begin
                ra    = 1'($urandom_range(0, 1));
                rem_a = $urandom_range(1, 9);
            end
            if (rem_b == 0) begin
                rb    = 1'($urandom_range(0, 1));
                rem_b = $urandom_range(1, 9);
                if ($urandom_range(0, 9) == 0) begin
                    rb    = ra;
                    rem_b = rem_a;
                end
            end
            rem_a--;
            rem_b--;
            if (in_rst) begin
                step(ra, rb, 1'b0, 1'b0);
                in_rst = 1'b0;
            end else begin
                drop = ($urandom_range(0, 199) == 0);
                step(ra, rb, 1'b1, drop);
                in_rst = drop;
            end
        end
        step(ra, rb, 1'b1, 1'b0);
        stim_done = 1'b1;
    end

    initial begin : monitor
        exp_t e;
        @(negedge clk);
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                if (stim_done) break;
                n_cmp++;
                n_bad++;
                $display("FAIL sb_empty at %0t: got no expectation, required one per cycle", $time);
            end else begin
                e = sb_q.pop_front();
                check("level", {b1, a1, b4, a4}, e.lvl);
                check("rise", {br1, ar1, br4, ar4}, e.rise);
                if (e.mid) begin
                    #3;
                    check("async_rst_level", {b1, a1, b4, a4}, 4'b0000);
                    check("async_rst_rise", {br1, ar1, br4, ar4}, 4'b0000);
                end
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog at %0t: got no end of run, required finish within time limit", $time);
        $fatal(1);
    end

endmodule
